// File: rtl/fc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_sched_if
// Description : Bundle of all fc_sched control, X buffer, X FIFO, W request
//               and completion signals.
//               master : viewed from the feed controller
//               slave  : viewed from the surrounding datapath / environment
//   start/cfg_*              : operation launch and configuration
//   busy/done                : operation status
//   xbuf_rd_*                : X buffer read port (1-cycle read latency)
//   x_fifo_*                 : X FIFO write port with vector markers
//   w_req_*                  : W burst request handshake
//   mat_end_last             : final-vector-end pulse from the synchronizer
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_sched_if #(
    parameter int X_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH    = 16
);
    logic                    start;
    logic [X_ADDR_WIDTH-1:0] cfg_x_base;
    logic [LEN_WIDTH-1:0]    cfg_x_len;
    logic [LEN_WIDTH-1:0]    cfg_n_passes;
    logic                    busy;
    logic                    done;

    logic                    xbuf_rd_en;
    logic [X_ADDR_WIDTH-1:0] xbuf_rd_addr;
    logic [8:0]              xbuf_rd_data;

    logic                    x_fifo_prog_full;
    logic                    x_fifo_wr_en;
    logic [8:0]              x_fifo_din;
    logic                    x_fifo_din_vec_begin;
    logic                    x_fifo_din_vec_end;
    logic                    x_fifo_din_last;

    logic                    w_req_valid;
    logic                    w_req_ready;
    logic [LEN_WIDTH-1:0]    w_req_len;

    logic                    mat_end_last;

    modport master (
        input  start, cfg_x_base, cfg_x_len, cfg_n_passes,
        input  xbuf_rd_data, x_fifo_prog_full, w_req_ready, mat_end_last,
        output busy, done, xbuf_rd_en, xbuf_rd_addr,
        output x_fifo_wr_en, x_fifo_din, x_fifo_din_vec_begin,
        output x_fifo_din_vec_end, x_fifo_din_last,
        output w_req_valid, w_req_len
    );

    modport slave (
        output start, cfg_x_base, cfg_x_len, cfg_n_passes,
        output xbuf_rd_data, x_fifo_prog_full, w_req_ready, mat_end_last,
        input  busy, done, xbuf_rd_en, xbuf_rd_addr,
        input  x_fifo_wr_en, x_fifo_din, x_fifo_din_vec_begin,
        input  x_fifo_din_vec_end, x_fifo_din_last,
        input  w_req_valid, w_req_len
    );
endinterface
`default_nettype wire

// File: rtl/fc_sched.sv
`default_nettype none
// ============================================================================
// Module      : fc_sched
// Description : FC-layer feed controller. On start it replays the resident X
//               vector once per output pass into the X FIFO (with
//               vec_begin / vec_end / last markers), issues one W burst
//               request per pass, then waits for the final vector end from
//               the PE-array input stage before pulsing done.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - fc_sched_if.master (control, X buffer read, X FIFO
//                      write, W request handshake, mat_end_last)
// Revision    : 1.0 - initial release
// ============================================================================
module fc_sched #(
    parameter int X_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH    = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    fc_sched_if.master bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Address arithmetic is done in the wider of the two widths and then
    // truncated, giving modulo-2^X_ADDR_WIDTH wrap of x_base + elem_idx.
    localparam int c_SUM_W = (X_ADDR_WIDTH > LEN_WIDTH) ? X_ADDR_WIDTH : LEN_WIDTH;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    w_done_nxt;

    logic [X_ADDR_WIDTH-1:0] r_x_base;
    logic [LEN_WIDTH-1:0]    r_x_len;
    logic [LEN_WIDTH-1:0]    r_n_passes;
    logic [LEN_WIDTH-1:0]    r_elem_idx;
    logic [LEN_WIDTH-1:0]    r_pass_idx;
    logic [LEN_WIDTH-1:0]    r_wreq_cnt;
    logic                    r_end_seen;
    logic                    r_done;

    logic                    r_wr_en;
    logic                    r_vec_begin;
    logic                    r_vec_end;
    logic                    r_last;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                    w_cfg_zero;
    logic                    w_start_ok;
    logic                    w_in_run;
    logic                    w_x_pending;
    logic                    w_issue;
    logic [LEN_WIDTH-1:0]    w_len_m1;
    logic [LEN_WIDTH-1:0]    w_pass_m1;
    logic                    w_elem_end;
    logic                    w_pass_final;
    logic                    w_wreq_pending;
    logic                    w_wreq_valid;
    logic                    w_wreq_fire;
    logic                    w_x_done;
    logic                    w_w_done;
    logic                    w_end_now;
    logic [c_SUM_W-1:0]      w_addr_sum;

    assign w_cfg_zero     = (bus.cfg_x_len == '0) || (bus.cfg_n_passes == '0);
    assign w_start_ok     = (r_state == c_ST_IDLE) && bus.start;
    assign w_in_run       = (r_state == c_ST_RUN);

    assign w_len_m1       = r_x_len - LEN_WIDTH'(1);
    assign w_pass_m1      = r_n_passes - LEN_WIDTH'(1);
    assign w_elem_end     = (r_elem_idx == w_len_m1);
    assign w_pass_final   = (r_pass_idx == w_pass_m1);

    // pass_idx reaches n_passes exactly when every X read has been issued.
    assign w_x_pending    = (r_pass_idx < r_n_passes);
    // prog_full leaves at least 2 free entries, so gating the read strobe
    // combinationally lets only the single in-flight element land after it.
    assign w_issue        = w_in_run && w_x_pending && !bus.x_fifo_prog_full;

    assign w_wreq_pending = (r_wreq_cnt < r_n_passes);
    assign w_wreq_valid   = w_in_run && w_wreq_pending;
    assign w_wreq_fire    = w_wreq_valid && bus.w_req_ready;

    // "Done" includes work completing in this very cycle so the final issue
    // and the final W handshake can coincide with the move to DRAIN.
    assign w_x_done       = !w_x_pending  || (w_issue && w_elem_end && w_pass_final);
    assign w_w_done       = !w_wreq_pending || (w_wreq_fire && (r_wreq_cnt == w_pass_m1));
    assign w_end_now      = r_end_seen || bus.mat_end_last;

    assign w_addr_sum     = c_SUM_W'(r_x_base) + c_SUM_W'(r_elem_idx);

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    if (w_cfg_zero) begin
                        // Degenerate operation: nothing to move, report at once.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                if (w_x_done && w_w_done) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_end_now) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_done      <= 1'b0;
            r_x_base    <= '0;
            r_x_len     <= '0;
            r_n_passes  <= '0;
            r_elem_idx  <= '0;
            r_pass_idx  <= '0;
            r_wreq_cnt  <= '0;
            r_end_seen  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_vec_begin <= 1'b0;
            r_vec_end   <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;

            if (w_start_ok && !w_cfg_zero) begin
                r_x_base   <= bus.cfg_x_base;
                r_x_len    <= bus.cfg_x_len;
                r_n_passes <= bus.cfg_n_passes;
                r_elem_idx <= '0;
                r_pass_idx <= '0;
                r_wreq_cnt <= '0;
                r_end_seen <= 1'b0;
            end else begin
                if (w_issue) begin
                    if (w_elem_end) begin
                        r_elem_idx <= '0;
                        r_pass_idx <= r_pass_idx + LEN_WIDTH'(1);
                    end else begin
                        r_elem_idx <= r_elem_idx + LEN_WIDTH'(1);
                    end
                end
                if (w_wreq_fire) begin
                    r_wreq_cnt <= r_wreq_cnt + LEN_WIDTH'(1);
                end
                if (bus.mat_end_last && (r_state != c_ST_IDLE)) begin
                    r_end_seen <= 1'b1;
                end
            end

            // Write strobe and markers travel one cycle behind the read so
            // they line up with the X buffer's read data.
            r_wr_en     <= w_issue;
            r_vec_begin <= w_issue && (r_elem_idx == '0);
            r_vec_end   <= w_issue && w_elem_end;
            r_last      <= w_issue && w_elem_end && w_pass_final;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy                 = (r_state != c_ST_IDLE);
    assign bus.done                 = r_done;
    assign bus.xbuf_rd_en           = w_issue;
    assign bus.xbuf_rd_addr         = w_addr_sum[X_ADDR_WIDTH-1:0];
    assign bus.x_fifo_wr_en         = r_wr_en;
    // Read data arrives in the write cycle; zero it when no write is active.
    assign bus.x_fifo_din           = r_wr_en ? bus.xbuf_rd_data : 9'd0;
    assign bus.x_fifo_din_vec_begin = r_vec_begin;
    assign bus.x_fifo_din_vec_end   = r_vec_end;
    assign bus.x_fifo_din_last      = r_last;
    assign bus.w_req_valid          = w_wreq_valid;
    assign bus.w_req_len            = r_x_len;

endmodule
`default_nettype wire

// File: doc/fc_sched.md
# fc_sched

FC-layer feed controller that sequences one fully-connected operation through the W/X synchronizer and PE array. On a start pulse it replays a resident X vector from the X buffer once per output pass into the X FIFO, tagging each element with vector-begin/vector-end/last markers. In parallel it issues one W burst request per pass to the DDR weight reader. It reports completion only after the PE-array input stage signals the final vector end.

## Interface
- X_ADDR_WIDTH, 12, X buffer address width
- LEN_WIDTH, 16, width of length/pass counters and config fields
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; samples cfg_*; ignored unless idle
- cfg_x_base  input  X_ADDR_WIDTH  first X buffer address of the vector
- cfg_x_len  input  LEN_WIDTH  elements per X vector
- cfg_n_passes  input  LEN_WIDTH  number of full X sweeps (output tiles)
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle completion pulse
- xbuf_rd_en  output  1  X buffer read strobe
- xbuf_rd_addr  output  X_ADDR_WIDTH  X buffer read address
- xbuf_rd_data  input  9  X buffer data, valid exactly 1 cycle after xbuf_rd_en
- x_fifo_prog_full  input  1  X FIFO programmable-full; asserted with at least 2 free entries remaining
- x_fifo_wr_en  output  1  X FIFO write strobe
- x_fifo_din  output  9  X element
- x_fifo_din_vec_begin  output  1  element is index 0 of a pass
- x_fifo_din_vec_end  output  1  element is index cfg_x_len-1 of a pass
- x_fifo_din_last  output  1  vec_end of the final pass
- w_req_valid  output  1  W burst request valid
- w_req_ready  input  1  W reader accepts request
- w_req_len  output  LEN_WIDTH  burst length in beats (equals latched cfg_x_len)
- mat_end_last  input  1  final-vector-end pulse from the synchronizer output

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on start. Latch x_base, x_len, n_passes. Clear elem_idx, pass_idx, wreq_cnt, and end_seen.
- start with cfg_x_len==0 or cfg_n_passes==0: stay IDLE, pulse done the next cycle, and generate no reads or requests.
- X read issue in RUN: xbuf_rd_en = (rd_pass < n_passes) && !x_fifo_prog_full. Address = x_base + elem_idx, modulo 2^X_ADDR_WIDTH.
- elem_idx wraps at x_len-1 → 0, and pass_idx increments on wrap.
- Markers are computed at issue and delayed 1 cycle alongside the read:
  - begin = (elem_idx==0)
  - end = (elem_idx==x_len-1)
  - last = end && (pass_idx==n_passes-1)
- x_len==1: begin and end both set on every element.
- x_fifo_wr_en, x_fifo_din, and all markers are registered 1 cycle after xbuf_rd_en. x_fifo_din = xbuf_rd_data.
- W requests in RUN: w_req_valid held high while wreq_cnt < n_passes. wreq_cnt increments on valid&&ready. w_req_valid is never deasserted without a handshake.
- W requests are independent of X progress. Up to n_passes requests may be outstanding.
- RUN → DRAIN when the last X read has been issued and all W requests have been accepted.
- end_seen is set by mat_end_last in RUN or DRAIN. mat_end_last is ignored in IDLE.
- DRAIN → IDLE when end_seen (latched, or arriving this cycle); done pulses on the same transition.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-operation drops any in-flight write: x_fifo_wr_en is 0 the cycle after reset.
- start at cycle T:
  - busy=1 at T+1.
  - First xbuf_rd_en at T+1 (if not prog_full) and first w_req_valid at T+1.
  - First x_fifo_wr_en at T+2.
- Throughput: 1 element/cycle while prog_full is low. At most 1 write follows prog_full assertion.
- done: asserted the cycle after the DRAIN exit condition is met, concurrent with busy falling to 0. The next start is accepted that same cycle.
- Simultaneous events:
  - w_req handshake and the final X issue in the same cycle → DRAIN next cycle.
  - mat_end_last in the same cycle as entering DRAIN → still counted.

## Test plan
- x_base=0x010, x_len=4, n_passes=3, FIFO never full, w_req_ready=1:
  - Required: 12 writes of data from addresses 0x010–0x013 ×3.
  - begin on writes 1/5/9; end on 4/8/12; last only on 12.
  - 3 W requests with len=4.
  - done 1 cycle after injected mat_end_last.
- x_len=1, n_passes=2 → 2 writes, each with begin=end=1; last only on the second.
- prog_full toggled every 3 cycles, w_req_ready random → no dropped or duplicated elements, element order preserved, never more than 1 write after prog_full rises.
- x_base=0xFFE, x_len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- cfg_x_len=0 → done at T+1, no xbuf_rd_en, no w_req_valid. A second start while busy is ignored (pass count unchanged).
- rst asserted mid-RUN with a read in flight → next cycle all outputs 0, busy=0. A new start then replays from elem 0, pass 0.
